aurora_tx_lane: RTL and testbench
=================================

Name: aurora_tx_lane

Overview:
- Transmit-side counterpart of aurora_rx_lane: one Aurora 64b/66b lane from block interface to a 32-bit serializer word.
- Accepts 64-bit payload + 2-bit sync header with a slot-based ready; scrambles payload (x^58+x^39+1, self-synchronous); header passes unscrambled.
- Inserts idle blocks when the source has nothing; a 66→32 gearbox emits one 32-bit word per clk_tx_i to the downstream OSERDES (MSB first on the wire).

Parameters:
IDLE_PAYLOAD, 64'h7800_0000_0000_0000, payload of inserted idle block (header fixed 2'b10)
CNT_WIDTH, 16, width of idle insertion counter

Ports:
clk_tx_i  in  1  lane word clock; single clock domain
rst_i  in  1  asynchronous, active-high reset
tx_data_i  in  64  block payload, bit 63 transmitted first
tx_header_i  in  2  sync header, bit 1 transmitted first
tx_valid_i  in  1  block offered
tx_ready_o  out  1  block slot open this cycle
tx_gb_data_o  out  32  serializer word, bit 31 transmitted first
tx_idle_cnt_o  out  CNT_WIDTH  saturating count of idle blocks inserted

Behaviour:
- Sequence counter seq 0..32, increments every cycle, wraps 32→0. Reset: seq=0.
- tx_ready_o = 1 when seq is even and seq != 32 (seq 0,2,…,30): 16 slots per 33 cycles. Combinational from seq; independent of tx_valid_i.
- Slot cycle: tx_valid_i=1 → block {tx_header_i, tx_data_i} accepted; tx_valid_i=0 → idle block {2'b10, IDLE_PAYLOAD} inserted, tx_idle_cnt_o +1 (saturates at all ones). Non-slot cycle: inputs ignored; source holds data until a slot.
- Scrambler: 58-bit state S, S[0] most recent. Per payload bit i=63 downto 0: o=d[i]^S[38]^S[57]; S={S[56:0],o}. State advances only on accepted/idle blocks. Reset: S all ones.
- Gearbox: 96-bit buffer with occupancy occ (reset 0). Slot cycle: append 66-bit scrambled block behind existing bits. Every cycle: remove oldest 32 bits into tx_gb_data_o (registered). Occupancy after each cycle follows 34,2,36,4,…,64,32,0 across seq 0..32; occ=0 exactly at wrap. Occupancy never below 32 before a pop; exceeding 96 is impossible by construction.
- Latency: header bits of block accepted at edge N appear in tx_gb_data_o[31:30] after edge N (valid from cycle N+1) when occ=0 at accept; otherwise behind the buffered bits.
- Reset values: tx_gb_data_o=0, tx_idle_cnt_o=0, tx_ready_o=1 (seq=0). Reset mid-block discards buffer and scrambler state; the first post-reset cycle is a slot.
- Never stalls: the output word is produced every cycle regardless of input.

Optional Feature:
- AURORA_TX_POLARITY_EN defined: adds input tx_polarity_i (1 bit). When 1, tx_gb_data_o is the bitwise inverse of the gearbox word (applied at the output register, same cycle). Scrambler/counter unaffected.
- Not defined: port absent, no inversion logic.

Test Plan:
- Reset, tx_valid_i=0 for 66 cycles → tx_ready_o high on seq 0,2,…,30 only; tx_idle_cnt_o=32 after 66 cycles; descrambled payloads all equal 64'h7800_0000_0000_0000.
- Reset, first slot tx_header_i=2'b01, tx_data_i=0 → first tx_gb_data_o word = 32'h4000_0000 (payload bits stay 0 until S[38] clears).
- 2000 counter blocks {2'b01,cnt,cnt} with tx_valid_i always high → loop via serializer model into aurora_rx_lane; after lock, zero mismatches, no gaps besides idles, tx_idle_cnt_o=0.
- tx_valid_i asserted at seq=31 and held → block accepted at seq=0 only; no duplication or loss over 500 blocks with random valid gaps.
- Assert rst_i for 1 cycle at seq=17 mid-stream → outputs 0, seq=0, S all ones; next block produces 32'h4000_0000 again for header 01 / zero payload.
- AURORA_TX_POLARITY_EN, tx_polarity_i=1, repeat scenario 2 → first word 32'hBFFF_FFFF; toggling back restores 32'h4000_0000 pattern next cycle.

Source files
------------

// File: rtl/aurora_tx_lane.sv
// Aurora 64b/66b transmit lane: slot-based block intake, self-synchronous scrambler,
// idle insertion and 66->32 gearbox. Optional output inversion via AURORA_TX_POLARITY_EN.
module aurora_tx_lane #(
  parameter logic [63:0] IDLE_PAYLOAD = 64'h7800_0000_0000_0000,
  parameter int          CNT_WIDTH    = 16
) (
  input  logic                 clk_tx_i,
  input  logic                 rst_i,
`ifdef AURORA_TX_POLARITY_EN
  input  logic                 tx_polarity_i,
`endif
  input  logic [63:0]          tx_data_i,
  input  logic [1:0]           tx_header_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [31:0]          tx_gb_data_o,
  output logic [CNT_WIDTH-1:0] tx_idle_cnt_o
);

  logic [5:0]  seq;
  logic [6:0]  occ;
  logic [95:0] gb_buf;
  logic [57:0] scr_state;

  logic        slot;
  logic [1:0]  blk_hdr;
  logic [63:0] blk_data;
  logic [63:0] scr_data;
  logic [57:0] scr_next;
  logic [57:0] scr_work;
  logic        scr_bit;
  logic [95:0] blk_ext;
  logic [95:0] merged;
  logic [6:0]  occ_next;
  logic [31:0] word_next;

  // Slots fall on even seq 0..30; seq 32 is the extra pop that drains the gearbox to 0.
  assign slot       = ~seq[0] && (seq != 6'd32);
  assign tx_ready_o = slot;

  always_comb begin
    blk_hdr  = tx_valid_i ? tx_header_i : 2'b10;
    blk_data = tx_valid_i ? tx_data_i   : IDLE_PAYLOAD;
    scr_work = scr_state;
    scr_data = '0;
    scr_bit  = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      scr_bit     = blk_data[i] ^ scr_work[38] ^ scr_work[57];
      scr_data[i] = scr_bit;
      scr_work    = {scr_work[56:0], scr_bit};
    end
    scr_next = scr_work;
  end

  // Buffer is MSB-aligned: oldest bit at [95]; a new block lands right behind occ valid bits.
  always_comb begin
    blk_ext  = {blk_hdr, scr_data, 30'b0} >> occ;
    merged   = slot ? (gb_buf | blk_ext) : gb_buf;
    occ_next = slot ? (occ + 7'd34) : (occ - 7'd32);
`ifdef AURORA_TX_POLARITY_EN
    word_next = merged[95:64] ^ {32{tx_polarity_i}};
`else
    word_next = merged[95:64];
`endif
  end

  always_ff @(posedge clk_tx_i or posedge rst_i) begin
    if (rst_i) begin
      seq           <= '0;
      occ           <= '0;
      gb_buf        <= '0;
      scr_state     <= '1;
      tx_gb_data_o  <= '0;
      tx_idle_cnt_o <= '0;
    end else begin
      seq          <= (seq == 6'd32) ? 6'd0 : seq + 6'd1;
      occ          <= occ_next;
      gb_buf       <= {merged[63:0], 32'b0};
      tx_gb_data_o <= word_next;
      if (slot) begin
        scr_state <= scr_next;
        if (!tx_valid_i && (tx_idle_cnt_o != '1))
          tx_idle_cnt_o <= tx_idle_cnt_o + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_aurora_tx_lane.sv
// Self-checking bench for aurora_tx_lane: directed first-word table plus a bit-serial
// reference model (bit queue) for idle runs, held-valid slots, random streams and reset.
module tb_aurora_tx_lane;

  localparam logic [63:0] IDLE = 64'h7800_0000_0000_0000;

  logic        clk_tx_i = 1'b0;
  logic        rst_i    = 1'b1;
  logic [63:0] tx_data_i = '0;
  logic [1:0]  tx_header_i = '0;
  logic        tx_valid_i = 1'b0;
  logic        tx_ready_o;
  logic [31:0] tx_gb_data_o;
  logic [15:0] tx_idle_cnt_o;
`ifdef AURORA_TX_POLARITY_EN
  logic        tx_polarity_i = 1'b0;
`endif

  always #5 clk_tx_i = ~clk_tx_i;

  aurora_tx_lane dut (
    .clk_tx_i      (clk_tx_i),
    .rst_i         (rst_i),
`ifdef AURORA_TX_POLARITY_EN
    .tx_polarity_i (tx_polarity_i),
`endif
    .tx_data_i     (tx_data_i),
    .tx_header_i   (tx_header_i),
    .tx_valid_i    (tx_valid_i),
    .tx_ready_o    (tx_ready_o),
    .tx_gb_data_o  (tx_gb_data_o),
    .tx_idle_cnt_o (tx_idle_cnt_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: serial scrambler feeding a plain bit queue.
  int          m_seq;
  bit          mq[$];
  logic [57:0] m_s;
  int          m_idle;
  logic [31:0] m_word;

  function automatic bit m_slot();
    return (m_seq % 2 == 0) && (m_seq != 32);
  endfunction

  task automatic model_reset();
    m_seq = 0; mq.delete(); m_s = '1; m_idle = 0; m_word = '0;
  endtask

  task automatic model_cycle(input logic v, input logic [1:0] h, input logic [63:0] d,
                             input logic pol);
    logic [1:0]  hh;
    logic [63:0] dd;
    logic        o;
    if (m_slot()) begin
      hh = v ? h : 2'b10;
      dd = v ? d : IDLE;
      mq.push_back(hh[1]);
      mq.push_back(hh[0]);
      for (int i = 63; i >= 0; i--) begin
        o = dd[i] ^ m_s[38] ^ m_s[57];
        m_s = {m_s[56:0], o};
        mq.push_back(o);
      end
      if (!v && m_idle < 65535) m_idle++;
    end
    if (mq.size() < 32) begin
      n_chk++;
      $display("FAIL model_underflow: got %0d bits required 32", mq.size());
      m_word = '0;
    end else begin
      for (int k = 31; k >= 0; k--) m_word[k] = mq.pop_front();
    end
    m_word = m_word ^ {32{pol}};
    m_seq = (m_seq == 32) ? 0 : m_seq + 1;
  endtask

  function automatic logic cur_pol();
`ifdef AURORA_TX_POLARITY_EN
    return tx_polarity_i;
`else
    return 1'b0;
`endif
  endfunction

  // One model-checked cycle; starts and ends at a negedge.
  task automatic cyc(input logic v, input logic [1:0] h, input logic [63:0] d);
    chk("ready", tx_ready_o, m_slot());
    tx_valid_i = v; tx_header_i = h; tx_data_i = d;
    model_cycle(v, h, d, cur_pol());
    @(posedge clk_tx_i);
    @(negedge clk_tx_i);
    chk("word", tx_gb_data_o, m_word);
    chk("idle_cnt", tx_idle_cnt_o, m_idle);
  endtask

  task automatic do_reset();
    @(negedge clk_tx_i);
    rst_i = 1'b1; tx_valid_i = 1'b0;
    @(negedge clk_tx_i);
    rst_i = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  h;
    logic [63:0] d;
    logic [31:0] exp_word;
    logic [15:0] exp_idle;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] cnt;
    bit          have;
    bit          acc;

    tbl[0] = '{1'b1, 2'b01, 64'h0,                    32'h4000_0000, 16'd0};
    tbl[1] = '{1'b1, 2'b10, 64'h0,                    32'h8000_0000, 16'd0};
    tbl[2] = '{1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF,  32'h7FFF_FFFF, 16'd0};
    tbl[3] = '{1'b1, 2'b00, 64'h8000_0000_0000_0000,  32'h2000_0000, 16'd0};
    tbl[4] = '{1'b0, 2'b01, 64'h1234_5678_9ABC_DEF0,  32'h9E00_0000, 16'd1};
    tbl[5] = '{1'b1, 2'b11, 64'hA5A5_A5A5_0000_0000,  32'hE969_6969, 16'd0};

    // Reset state while reset is held.
    #1;
    chk("rst_word", tx_gb_data_o, 32'h0);
    chk("rst_idle", tx_idle_cnt_o, 16'h0);
    chk("rst_ready", tx_ready_o, 1'b1);

    // First word after reset for a single block at the seq 0 slot.
    foreach (tbl[i]) begin
      do_reset();
      chk("tbl_ready", tx_ready_o, 1'b1);
      tx_valid_i = tbl[i].v; tx_header_i = tbl[i].h; tx_data_i = tbl[i].d;
      model_cycle(tbl[i].v, tbl[i].h, tbl[i].d, 1'b0);
      @(posedge clk_tx_i);
      @(negedge clk_tx_i);
      chk("tbl_word", tx_gb_data_o, tbl[i].exp_word);
      chk("tbl_idle", tx_idle_cnt_o, tbl[i].exp_idle);
    end

    // 66 idle cycles: ready pattern, words vs model, 32 idles inserted.
    do_reset();
    for (int c = 0; c < 66; c++) cyc(1'b0, 2'b00, 64'h0);
    chk("idle66_cnt", tx_idle_cnt_o, 16'd32);

    // Valid raised at seq 31 and held: no acceptance at 31/32, accepted at seq 0.
    do_reset();
    for (int c = 0; c < 31; c++) cyc(1'b0, 2'b00, 64'h0);
    chk("hold_seq31_ready", tx_ready_o, 1'b0);
    cyc(1'b1, 2'b01, 64'hDEAD_BEEF_0000_0001);
    chk("hold_seq32_ready", tx_ready_o, 1'b0);
    cyc(1'b1, 2'b01, 64'hDEAD_BEEF_0000_0001);
    chk("hold_seq0_ready", tx_ready_o, 1'b1);
    cyc(1'b1, 2'b01, 64'hDEAD_BEEF_0000_0001);
    cyc(1'b0, 2'b00, 64'h0);
    chk("hold_idle_cnt", tx_idle_cnt_o, 16'd16);

    // Full-rate stream: valid always high, no idles.
    do_reset();
    cnt = 0;
    for (int c = 0; c < 330; c++) begin
      acc = m_slot();
      cyc(1'b1, 2'b01, {cnt[31:0], cnt[31:0]});
      if (acc) cnt++;
    end
    chk("full_rate_idle", tx_idle_cnt_o, 16'd0);
    chk("full_rate_blocks", cnt, 64'd160);

    // Random gaps with a source that holds its block until a slot takes it.
    do_reset();
    cnt = 0; have = 0;
    for (int c = 0; c < 1100; c++) begin
      if (!have && $urandom_range(0, 3) != 0) have = 1;
      acc = m_slot() && have;
      cyc(have, 2'b01, {cnt[31:0], ~cnt[31:0]});
      if (acc) begin cnt++; have = 0; end
    end

    // Reset for one cycle at seq 17 mid-stream, then restart cleanly.
    do_reset();
    for (int c = 0; c < 17; c++) cyc(1'b1, 2'b10, 64'h0123_4567_89AB_CDEF);
    chk("pre_rst_seq17_ready", tx_ready_o, 1'b0);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_word", tx_gb_data_o, 32'h0);
    chk("mid_rst_idle", tx_idle_cnt_o, 16'h0);
    chk("mid_rst_ready", tx_ready_o, 1'b1);
    @(negedge clk_tx_i);
    rst_i = 1'b0;
    model_reset();
    cyc(1'b1, 2'b01, 64'h0);
    chk("post_rst_word", tx_gb_data_o, 32'h4000_0000);
    for (int c = 0; c < 40; c++) cyc(1'b1, 2'b01, 64'h0);

`ifdef AURORA_TX_POLARITY_EN
    do_reset();
    tx_polarity_i = 1'b1;
    cyc(1'b1, 2'b01, 64'h0);
    chk("pol_first_word", tx_gb_data_o, 32'hBFFF_FFFF);
    tx_polarity_i = 1'b0;
    cyc(1'b0, 2'b00, 64'h0);
    for (int c = 0; c < 20; c++) begin
      tx_polarity_i = c[0];
      cyc(1'b1, 2'b01, 64'h0);
    end
    tx_polarity_i = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
